// File: rtl/cpu_v1_pkg.sv
// Shared constants and types for the v1 CPU issue path.
package cpu_v1_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    // Encodings match the ALU's opcode input so funct3 can be passed straight through.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

    function automatic logic is_alu_funct3(input logic [2:0] f3);
        return (f3 == ALU_ADD) || (f3 == ALU_XOR) || (f3 == ALU_OR) || (f3 == ALU_AND);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, x0 tied to zero.
module regfile_2r1w (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-cycle fetch/decode/exec/writeback issuer for RV32I OP and OP-IMM ALU instructions.
// Define ALU_ISSUE_HALT_ON_ILLEGAL_EN to halt on illegal instructions instead of treating them as NOPs.
module alu_issue_ctrl
    import cpu_v1_pkg::*;
#(
    parameter int          IMEM_AW  = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        alu_src1,
    output logic [31:0]        alu_src2,
    output logic [2:0]         alu_oper,
    input  logic [31:0]        alu_res,
    output logic               halted,
    output logic               dbg_wb_en,
    output logic [4:0]         dbg_wb_rd,
    output logic [31:0]        dbg_wb_data
);

    state_t             state;
    logic [IMEM_AW-1:0] pc;
    logic [31:0]        ir;
    logic [31:0]        wb_data;
    logic               wb_legal;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        is_op;
    logic        is_opimm;
    logic        is_legal;
    logic        is_ecall;
    logic        wr_en;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};

    assign is_op    = (opcode == OPC_OP) && (funct7 == 7'd0);
    assign is_opimm = (opcode == OPC_OPIMM);
    assign is_legal = (is_op || is_opimm) && is_alu_funct3(funct3);
    assign is_ecall = (ir == ECALL_WORD);

    regfile_2r1w u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (wr_en),
        .waddr  (rd),
        .wdata  (wb_data)
    );

    // Operands track ir in every state; the ALU result only matters during EXEC.
    assign alu_src1 = rs1_data;
    assign alu_src2 = is_opimm ? imm_i : rs2_data;
    assign alu_oper = funct3;

    assign wr_en       = (state == ST_WB) && wb_legal && (rd != 5'd0);
    assign dbg_wb_en   = wr_en;
    assign dbg_wb_rd   = wr_en ? rd : 5'd0;
    assign dbg_wb_data = wr_en ? wb_data : 32'd0;
    assign halted      = (state == ST_HALT);
    assign imem_addr   = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            pc       <= IMEM_AW'(RESET_PC);
            ir       <= '0;
            wb_data  <= '0;
            wb_legal <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir    <= imem_rdata;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_ecall) begin
                        state <= ST_HALT;
                    end else if (is_legal) begin
                        wb_data  <= alu_res;
                        wb_legal <= 1'b1;
                        state    <= ST_WB;
                    end else begin
`ifdef ALU_ISSUE_HALT_ON_ILLEGAL_EN
                        state <= ST_HALT;
`else
                        wb_legal <= 1'b0;
                        state    <= ST_WB;
`endif
                    end
                end
                ST_WB: begin
                    pc    <= pc + 1'b1;
                    state <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: an instruction-level reference model compared every cycle.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [2:0]  alu_oper;
    logic [31:0] alu_res;
    logic        halted;
    logic        dbg_wb_en;
    logic [4:0]  dbg_wb_rd;
    logic [31:0] dbg_wb_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] imem [256];

    // Reference model: architectural state plus position within the 4-cycle instruction.
    logic [31:0] mregs [32];
    logic [7:0]  mpc;
    int          mphase;
    logic        mhalted;

    // Observed DUT behaviour used by the literal spot checks.
    logic [31:0] dutRegs [32];
    int          wbCount;
    logic [31:0] lastExecSrc2;
    logic [2:0]  lastExecOper;

    alu_issue_ctrl #(.IMEM_AW(8), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_oper    (alu_oper),
        .alu_res     (alu_res),
        .halted      (halted),
        .dbg_wb_en   (dbg_wb_en),
        .dbg_wb_rd   (dbg_wb_rd),
        .dbg_wb_data (dbg_wb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem[imem_addr];

    always_comb begin
        alu_res = 32'd0;
        case (alu_oper)
            3'b000: alu_res = alu_src1 + alu_src2;
            3'b100: alu_res = alu_src1 ^ alu_src2;
            3'b110: alu_res = alu_src1 | alu_src2;
            3'b111: alu_res = alu_src1 & alu_src2;
            default: alu_res = 32'd0;
        endcase
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic modelLegal(input logic [31:0] w);
        logic [2:0] f3;
        logic       f3ok;
        f3   = w[14:12];
        f3ok = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd6) || (f3 == 3'd7);
        if (w[6:0] == 7'h33) return f3ok && (w[31:25] == 7'd0);
        if (w[6:0] == 7'h13) return f3ok;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelOperand2(input logic [31:0] w);
        if (w[6:0] == 7'h13) return 32'($signed(w[31:20]));
        return mregs[w[24:20]];
    endfunction

    function automatic logic [31:0] modelResult(input logic [31:0] w);
        logic [31:0] a;
        logic [31:0] b;
        a = mregs[w[19:15]];
        b = modelOperand2(w);
        case (w[14:12])
            3'd0: return a + b;
            3'd4: return a ^ b;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic modelHaltsOn(input logic [31:0] w);
        if (w == 32'h0000_0073) return 1'b1;
`ifdef ALU_ISSUE_HALT_ON_ILLEGAL_EN
        if (!modelLegal(w)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) begin
            mregs[i]   = 32'd0;
            dutRegs[i] = 32'hDEAD_BEEF;
        end
        mpc     = 8'd0;
        mphase  = 0;
        mhalted = 1'b0;
        wbCount = 0;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput();
        logic [31:0] w;
        logic        expWb;
        w = imem[mpc];
        checkVal("halted", 32'(halted), 32'(mhalted));
        checkVal("imem_addr", 32'(imem_addr), 32'(mpc));
        expWb = !mhalted && (mphase == 3) && modelLegal(w) && (w[11:7] != 5'd0);
        checkVal("wb_en", 32'(dbg_wb_en), 32'(expWb));
        if (expWb) begin
            checkVal("wb_rd", 32'(dbg_wb_rd), 32'(w[11:7]));
            checkVal("wb_data", dbg_wb_data, modelResult(w));
        end else if (mhalted || mphase != 3) begin
            checkVal("wb_rd_idle", 32'(dbg_wb_rd), 32'd0);
            checkVal("wb_data_idle", dbg_wb_data, 32'd0);
        end
        if (!mhalted && mphase == 2) begin
            checkVal("alu_oper", 32'(alu_oper), 32'(w[14:12]));
            checkVal("alu_src1", alu_src1, mregs[w[19:15]]);
            checkVal("alu_src2", alu_src2, modelOperand2(w));
            lastExecSrc2 = alu_src2;
            lastExecOper = alu_oper;
        end
        if (dbg_wb_en) begin
            dutRegs[dbg_wb_rd] = dbg_wb_data;
            wbCount++;
        end
    endtask

    task automatic advanceModel();
        logic [31:0] w;
        if (mhalted) return;
        w = imem[mpc];
        if (mphase == 2 && modelHaltsOn(w)) begin
            mhalted = 1'b1;
            return;
        end
        if (mphase == 3) begin
            if (modelLegal(w) && w[11:7] != 5'd0) mregs[w[11:7]] = modelResult(w);
            mpc = mpc + 8'd1;
        end
        mphase = (mphase + 1) % 4;
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            advanceModel();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
    endtask

    task automatic fillNops();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    endtask

    int wbBefore;

    initial begin
        fillNops();
        imem[0] = 32'h0050_0093;
        imem[1] = 32'hFFF0_0113;
        imem[2] = 32'h0020_C1B3;
        imem[3] = 32'h0070_0013;
        imem[4] = 32'h0000_0233;
        imem[5] = 32'h4020_8233;
        imem[6] = 32'h0000_0073;
        modelReset();
        #1;
        checkVal("reset_addr", 32'(imem_addr), 32'd0);
        checkVal("reset_halted", 32'(halted), 32'd0);
        checkVal("reset_alu_src1", alu_src1, 32'd0);
        doReset();

        applyStimulus(4);
        #1;
        checkVal("addi_x1", dutRegs[1], 32'd5);
        checkVal("addi_next_pc", 32'(imem_addr), 32'd1);

        applyStimulus(8);
        #1;
        checkVal("xor_oper", 32'(lastExecOper), 32'd4);
        checkVal("xor_src2", lastExecSrc2, 32'hFFFF_FFFF);
        checkVal("xor_x3", dutRegs[3], 32'hFFFF_FFFA);

        wbBefore = wbCount;
        applyStimulus(4);
        #1;
        checkVal("x0_no_write", 32'(wbCount), 32'(wbBefore));

        applyStimulus(4);
        #1;
        checkVal("add_x4_zero", dutRegs[4], 32'd0);

        wbBefore = wbCount;
        applyStimulus(4);
        #1;
        checkVal("illegal_no_write", 32'(wbCount), 32'(wbBefore));
`ifdef ALU_ISSUE_HALT_ON_ILLEGAL_EN
        checkVal("illegal_halted", 32'(halted), 32'd1);
        checkVal("illegal_pc", 32'(imem_addr), 32'd5);
`else
        checkVal("illegal_halted", 32'(halted), 32'd0);
        checkVal("illegal_pc", 32'(imem_addr), 32'd6);
`endif
        applyStimulus(8);
        #1;
        checkVal("ecall_halted", 32'(halted), 32'd1);

        // Asynchronous reset in the middle of EXEC with pc = 3.
        imem[3] = 32'h00A0_0293;
        doReset();
        applyStimulus(14);
        #3 rst = 1'b1;
        #1;
        checkVal("midreset_addr", 32'(imem_addr), 32'd0);
        checkVal("midreset_halted", 32'(halted), 32'd0);
        checkVal("midreset_wb_en", 32'(dbg_wb_en), 32'd0);
        checkVal("midreset_oper", 32'(alu_oper), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        applyStimulus(4);
        #1;
        checkVal("post_reset_fetch1", 32'(imem_addr), 32'd1);

        // ECALL at the top address freezes pc there.
        fillNops();
        imem[255] = 32'h0000_0073;
        doReset();
        applyStimulus(256 * 4 + 4);
        #1;
        checkVal("top_halted", 32'(halted), 32'd1);
        checkVal("top_pc", 32'(imem_addr), 32'd255);

        // A legal instruction at the top address wraps pc to 0.
        imem[255] = 32'h0000_0013;
        doReset();
        applyStimulus(256 * 4);
        #1;
        checkVal("wrap_pc", 32'(imem_addr), 32'd0);
        checkVal("wrap_halted", 32'(halted), 32'd0);
        applyStimulus(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
